// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset CPU: FSM states, opcodes,
// function codes, ALU control vector and the control bundle.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ALU_CTRL_W = 4;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MUL  = 6'b000010;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_AND, ALU_NOR, ALU_OR,
        ALU_XOR, ALU_SLL, ALU_SRL, ALU_MUL, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JMP, PC_REG} pc_sel_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;

    typedef struct packed {
        logic    ir_we;
        logic    ab_we;
        logic    aluout_we;
        logic    mdr_we;
        logic    rf_we;
        logic    ram_we;
        logic    pc_we;
        logic    retire;
        logic    mul_busy;
        logic    alu_src_imm;
        pc_sel_e pc_sel;
        wb_sel_e wb_sel;
        alu_op_e alu_op;
        logic [4:0] rf_wa;
    } ctrl_t;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU with a fixed-latency multiply; alu_end flags the multiply result as valid.
module alu
    import cpu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  shamt_i,
    input  logic        mul_busy_i,
    output logic [31:0] result_c_o,
    output logic        alu_end_c_o
);
    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts extra EX cycles of a multiply; clears as soon as the result is taken.
    assign alu_end_c_o = (cnt_q == CNT_W'(MUL_LAT));
    assign cnt_d       = (mul_busy_i && !alu_end_c_o) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        result_c_o = '0;
        case (op_i)
            ALU_ADD: result_c_o = a_i + b_i;
            ALU_SUB: result_c_o = a_i - b_i;
            ALU_SLT: result_c_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            ALU_AND: result_c_o = a_i & b_i;
            ALU_NOR: result_c_o = ~(a_i | b_i);
            ALU_OR:  result_c_o = a_i | b_i;
            ALU_XOR: result_c_o = a_i ^ b_i;
            ALU_SLL: result_c_o = b_i << shamt_i;
            ALU_SRL: result_c_o = b_i >> shamt_i;
            ALU_MUL: result_c_o = a_i * b_i;
            ALU_LUI: result_c_o = {b_i[15:0], 16'h0000};
            default: result_c_o = '0;
        endcase
    end
endmodule

// File: rtl/data_ram.sv
// Word-addressed data RAM: one synchronous write port, CPU and debug asynchronous reads.
module data_ram #(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [31:0]   rdata_c_o,
    output logic [31:0]   dbg_rdata_c_o
);
    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_c_o     = mem_q[addr_i];
    assign dbg_rdata_c_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/inst_rom.sv
// Instruction ROM whose contents come from a packed image parameter (word 0 in the LSBs).
module inst_rom #(
    parameter int unsigned            AW   = 5,
    parameter logic [32*(2**AW)-1:0]  INIT = '0
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   data_c_o
);
    assign data_c_o = INIT[32*addr_i +: 32];
endmodule

// File: rtl/mc_control.sv
// Instruction decode plus the IF/ID/EX/MEM/WB sequencer that strobes the datapath.
module mc_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ir_i,
    input  logic        a_eq_b_i,
    input  logic        alu_end_i,
    output state_e      state_o,
    output ctrl_t       ctrl_c_o
);
    state_e     state_q, state_d;
    logic [5:0] op, fn;
    logic       is_alu_r, is_mul, is_addiu, is_lui, is_lw, is_sw;
    logic       is_beq, is_bne, is_j, is_jal, is_jr, br_taken;
    alu_op_e    alu_op;
    logic       unused_c;

    assign op       = ir_i[31:26];
    assign fn       = ir_i[5:0];
    assign unused_c = ^{ir_i[25:21], ir_i[10:6]};
    assign br_taken = (is_beq && a_eq_b_i) || (is_bne && !a_eq_b_i);
    assign state_o  = state_q;

    always_comb begin
        is_alu_r = 1'b0; is_mul = 1'b0; is_addiu = 1'b0; is_lui = 1'b0;
        is_lw    = 1'b0; is_sw  = 1'b0; is_beq   = 1'b0; is_bne = 1'b0;
        is_j     = 1'b0; is_jal = 1'b0; is_jr    = 1'b0;
        alu_op   = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                is_alu_r = 1'b1;
                case (fn)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_AND:  alu_op = ALU_AND;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_JR:   begin is_alu_r = 1'b0; is_jr = 1'b1; end
                    default: is_alu_r = 1'b0;
                endcase
            end
            OP_SPECIAL2: if (fn == FN_MUL) begin is_mul = 1'b1; alu_op = ALU_MUL; end
            OP_ADDIU:    is_addiu = 1'b1;
            OP_LUI:      begin is_lui = 1'b1; alu_op = ALU_LUI; end
            OP_LW:       is_lw  = 1'b1;
            OP_SW:       is_sw  = 1'b1;
            OP_BEQ:      is_beq = 1'b1;
            OP_BNE:      is_bne = 1'b1;
            OP_J:        is_j   = 1'b1;
            OP_JAL:      is_jal = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IF;
        else         state_q <= state_d;
    end

    // Any final-state exit retires the instruction and advances the PC.
    always_comb begin
        state_d              = ST_IF;
        ctrl_c_o             = '0;
        ctrl_c_o.pc_sel      = PC_SEQ;
        ctrl_c_o.alu_op      = alu_op;
        ctrl_c_o.alu_src_imm = !(is_alu_r || is_mul);
        ctrl_c_o.wb_sel      = is_lw ? WB_MEM : (is_jal ? WB_LINK : WB_ALU);
        ctrl_c_o.rf_wa       = is_jal ? 5'd31 : ((is_alu_r || is_mul) ? ir_i[15:11] : ir_i[20:16]);
        case (state_q)
            ST_IF: begin
                ctrl_c_o.ir_we = 1'b1;
                state_d        = ST_ID;
            end
            ST_ID: begin
                ctrl_c_o.ab_we = 1'b1;
                state_d        = ST_EX;
            end
            ST_EX: begin
                ctrl_c_o.aluout_we = 1'b1;
                if (is_beq || is_bne || is_j || is_jr) begin
                    ctrl_c_o.retire = 1'b1;
                    ctrl_c_o.pc_we  = 1'b1;
                    if (is_j)          ctrl_c_o.pc_sel = PC_JMP;
                    else if (is_jr)    ctrl_c_o.pc_sel = PC_REG;
                    else if (br_taken) ctrl_c_o.pc_sel = PC_BR;
                    state_d = ST_IF;
                end else if (is_mul) begin
                    ctrl_c_o.mul_busy = 1'b1;
                    state_d           = alu_end_i ? ST_WB : ST_EX;
                end else if (is_lw || is_sw) begin
                    state_d = ST_MEM;
                end else if (is_alu_r || is_addiu || is_lui || is_jal) begin
                    state_d = ST_WB;
                end else begin
                    ctrl_c_o.retire = 1'b1;
                    ctrl_c_o.pc_we  = 1'b1;
                    state_d         = ST_IF;
                end
            end
            ST_MEM: begin
                if (is_sw) begin
                    ctrl_c_o.ram_we = 1'b1;
                    ctrl_c_o.retire = 1'b1;
                    ctrl_c_o.pc_we  = 1'b1;
                    state_d         = ST_IF;
                end else begin
                    ctrl_c_o.mdr_we = 1'b1;
                    state_d         = ST_WB;
                end
            end
            ST_WB: begin
                ctrl_c_o.rf_we  = 1'b1;
                ctrl_c_o.retire = 1'b1;
                ctrl_c_o.pc_we  = 1'b1;
                ctrl_c_o.pc_sel = is_jal ? PC_JMP : PC_SEQ;
                state_d         = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
        // A reset edge must never commit architectural writes, even mid-instruction.
        if (!resetn) begin
            ctrl_c_o.rf_we  = 1'b0;
            ctrl_c_o.ram_we = 1'b0;
        end
    end
endmodule

// File: rtl/regfile.sv
// 32x32 register file: two operand read ports, one debug read port, r0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  ra3_i,
    output logic [31:0] rd1_c_o,
    output logic [31:0] rd2_c_o,
    output logic [31:0] rd3_c_o
);
    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (we_i && (wa_i != 5'd0)) regs_q[wa_i] <= wd_i;
    end

    assign rd1_c_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_c_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];
    assign rd3_c_o = (ra3_i == 5'd0) ? 32'd0 : regs_q[ra3_i];
endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset CPU: datapath registers around regfile, ALU, ROM and RAM,
// sequenced by mc_control. IMEM_INIT carries the program image.
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0]                 START_ADDR = 32'h0000_0000,
    parameter int unsigned                 IMEM_AW    = 5,
    parameter int unsigned                 DMEM_AW    = 5,
    parameter logic [32*(2**IMEM_AW)-1:0]  IMEM_INIT  = '0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  rf_addr,
    input  logic [31:0] mem_addr,
    output logic [31:0] rf_data,
    output logic [31:0] mem_data,
    output logic [31:0] cpu_pc,
    output logic [31:0] cpu_inst,
    output logic [2:0]  cpu_state,
    output logic [31:0] retire_cnt
);
    logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, imm_q, aluout_q, mdr_q, retire_q;
    logic [31:0] pc_plus4, br_target, j_target;
    logic [31:0] rom_word, rd1, rd2, ram_rdata, alu_b, alu_y, wb_data;
    logic        alu_end;
    state_e      state;
    ctrl_t       ctrl;
    logic        unused_c;

    assign unused_c = ^{mem_addr[31:DMEM_AW+2], mem_addr[1:0]};

    mc_control u_ctrl (
        .clk       (clk),
        .resetn    (resetn),
        .ir_i      (ir_q),
        .a_eq_b_i  (a_q == b_q),
        .alu_end_i (alu_end),
        .state_o   (state),
        .ctrl_c_o  (ctrl)
    );

    inst_rom #(.AW(IMEM_AW), .INIT(IMEM_INIT)) u_rom (
        .addr_i   (pc_q[IMEM_AW+1:2]),
        .data_c_o (rom_word)
    );

    regfile u_rf (
        .clk     (clk),
        .we_i    (ctrl.rf_we),
        .wa_i    (ctrl.rf_wa),
        .wd_i    (wb_data),
        .ra1_i   (ir_q[25:21]),
        .ra2_i   (ir_q[20:16]),
        .ra3_i   (rf_addr),
        .rd1_c_o (rd1),
        .rd2_c_o (rd2),
        .rd3_c_o (rf_data)
    );

    alu u_alu (
        .clk         (clk),
        .resetn      (resetn),
        .op_i        (ctrl.alu_op),
        .a_i         (a_q),
        .b_i         (alu_b),
        .shamt_i     (ir_q[10:6]),
        .mul_busy_i  (ctrl.mul_busy),
        .result_c_o  (alu_y),
        .alu_end_c_o (alu_end)
    );

    data_ram #(.AW(DMEM_AW)) u_ram (
        .clk           (clk),
        .we_i          (ctrl.ram_we),
        .addr_i        (aluout_q[DMEM_AW+1:2]),
        .wdata_i       (b_q),
        .dbg_addr_i    (mem_addr[DMEM_AW+1:2]),
        .rdata_c_o     (ram_rdata),
        .dbg_rdata_c_o (mem_data)
    );

    assign alu_b     = ctrl.alu_src_imm ? imm_q : b_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        pc_d = pc_plus4;
        case (ctrl.pc_sel)
            PC_BR:   pc_d = br_target;
            PC_JMP:  pc_d = j_target;
            PC_REG:  pc_d = a_q;
            default: pc_d = pc_plus4;
        endcase
    end

    always_comb begin
        wb_data = aluout_q;
        case (ctrl.wb_sel)
            WB_MEM:  wb_data = mdr_q;
            WB_LINK: wb_data = pc_plus4;
            default: wb_data = aluout_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q     <= START_ADDR;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            retire_q <= '0;
        end else begin
            if (ctrl.ir_we) ir_q <= rom_word;
            if (ctrl.ab_we) begin
                a_q   <= rd1;
                b_q   <= rd2;
                imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
            end
            if (ctrl.aluout_we) aluout_q <= alu_y;
            if (ctrl.mdr_we)    mdr_q    <= ram_rdata;
            if (ctrl.pc_we)     pc_q     <= pc_d;
            if (ctrl.retire)    retire_q <= retire_q + 32'd1;
        end
    end

    assign cpu_pc     = pc_q;
    assign cpu_inst   = ir_q;
    assign cpu_state  = 3'(state);
    assign retire_cnt = retire_q;
endmodule
